// File: rtl/comb_calc.sv
// Registered signed two-operand calculator: add, subtract in either operand
// order and absolute value, with a per-result overflow flag and a sticky overflow.
module comb_calc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [2:0]   OP,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         clr_sticky,
    output logic [W-1:0] R,
    output logic         ovf,
    output logic         out_valid,
    output logic         ovf_sticky
);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    function automatic logic add_ovf(input logic sx, input logic sy, input logic sr);
        return (sx == sy) && (sr != sx);
    endfunction

    function automatic logic sub_ovf(input logic sx, input logic sy, input logic sr);
        return (sx != sy) && (sr != sx);
    endfunction

    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_neg_y;
    logic [W-1:0] w_res;
    logic         w_ovf;

    logic [W-1:0] r_res;
    logic         r_ovf;
    logic         r_valid;
    logic         r_sticky;

    // OP[2] swaps the operand roles, so B+A / B-A / |A| reuse the A-first datapath.
    assign w_x     = OP[2] ? B : A;
    assign w_y     = OP[2] ? A : B;
    assign w_sum   = w_x + w_y;
    assign w_diff  = w_x - w_y;
    assign w_neg_y = {W{1'b0}} - w_y;

    // Result and overflow selection from the low opcode bits.
    always_comb begin
        w_res = w_sum;
        w_ovf = 1'b0;
        case (OP[1:0])
            2'b00: begin
                w_res = w_sum;
                w_ovf = add_ovf(w_x[W-1], w_y[W-1], w_sum[W-1]);
            end
            2'b01: begin
                w_res = w_diff;
                w_ovf = sub_ovf(w_x[W-1], w_y[W-1], w_diff[W-1]);
            end
            2'b10, 2'b11: begin
                if (w_y[W-1]) begin
                    w_res = w_neg_y;
                end else begin
                    w_res = w_y;
                end
                // Negating the most-negative value wraps back onto itself.
                w_ovf = (w_y == MOST_NEG);
            end
            default: begin
                w_res = w_sum;
                w_ovf = 1'b0;
            end
        endcase
    end

    // Result register: loads on a valid capture, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= {W{1'b0}};
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_res <= w_res;
                r_ovf <= w_ovf;
            end else begin
                r_res <= r_res;
                r_ovf <= r_ovf;
            end
        end
    end

    // Sticky overflow: a captured overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (in_valid && w_ovf) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= r_sticky;
        end
    end

    assign R          = r_res;
    assign ovf        = r_ovf;
    assign out_valid  = r_valid;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_comb_calc.sv
// Scoreboard bench for comb_calc: directed vectors push hand-computed results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_comb_calc;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] r;
        logic         ovf;
        logic         sticky;
        int           due;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   OP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         clr_sticky;
    logic [W-1:0] R;
    logic         ovf;
    logic         out_valid;
    logic         ovf_sticky;

    exp_t         sb[$];
    int           n_cmp;
    int           n_err;
    int           cyc;
    logic         m_sticky;
    logic [W-1:0] last_r;
    logic         last_ovf;

    comb_calc #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .OP         (OP),
        .A          (A),
        .B          (B),
        .clr_sticky (clr_sticky),
        .R          (R),
        .ovf        (ovf),
        .out_valid  (out_valid),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp = n_cmp + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per presented result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_R"}, {16'h0, R}, {16'h0, e.r});
                check({e.name, "_ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
                check({e.name, "_sticky"}, {31'h0, ovf_sticky}, {31'h0, e.sticky});
                check({e.name, "_latency"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] op, input int a, input int b,
                         input logic clr, input int exp_r, input logic exp_ovf);
        exp_t e;
        @(negedge clk);
        in_valid   = 1'b1;
        OP         = op;
        A          = a[W-1:0];
        B          = b[W-1:0];
        clr_sticky = clr;
        if (exp_ovf) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        e.r      = exp_r[W-1:0];
        e.ovf    = exp_ovf;
        e.sticky = m_sticky;
        e.due    = cyc + 1;
        e.name   = name;
        sb.push_back(e);
        last_r   = exp_r[W-1:0];
        last_ovf = exp_ovf;
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("hold_R", {16'h0, R}, {16'h0, last_r});
                check("hold_ovf", {31'h0, ovf}, {31'h0, last_ovf});
                check("hold_out_valid", {31'h0, out_valid}, 32'h0);
            end
            in_valid   = 1'b0;
            clr_sticky = 1'b0;
            OP         = 3'($urandom_range(7, 0));
            A          = 16'($urandom);
            B          = 16'($urandom);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        cyc        = 0;
        m_sticky   = 1'b0;
        last_r     = 16'h0;
        last_ovf   = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        OP         = 3'b000;
        A          = 16'h0;
        B          = 16'h0;
        clr_sticky = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_R", {16'h0, R}, 32'h0);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        rst_n = 1'b1;

        issue("add_10_5",     3'b000,  10,   5,  1'b0,  15, 1'b0);
        issue("add_m15_30",   3'b000, -15,  30,  1'b0,  15, 1'b0);
        issue("sub_20_5",     3'b001,  20,   5,  1'b0,  15, 1'b0);
        issue("sub_m10_m25",  3'b001, -10, -25,  1'b0,  15, 1'b0);
        issue("badd_m40_100", 3'b100, -40, 100,  1'b0,  60, 1'b0);
        issue("bsub_10_5",    3'b101,  10,   5,  1'b0,  -5, 1'b0);
        issue("bsub_m50_20",  3'b101, -50,  20,  1'b0,  70, 1'b0);
        issue("absb_m100",    3'b010,   7, -100, 1'b0, 100, 1'b0);
        issue("absb_77",      3'b011,  -3,  77,  1'b0,  77, 1'b0);
        issue("absa_m45",     3'b110, -45,   9,  1'b0,  45, 1'b0);
        issue("absa_30",      3'b111,  30,  -9,  1'b0,  30, 1'b0);
        issue("absa_0",       3'b110,   0, -1,   1'b0,   0, 1'b0);
        idle_hold(4);

        issue("add_ovf",      3'b000,  32760,  100,   1'b0, -32676, 1'b1);
        issue("after_ovf",    3'b000,  1,      2,     1'b0,  3,     1'b0);
        issue("sub_ovf",      3'b001, -32760,  100,   1'b0,  32676, 1'b1);
        issue("absb_min_010", 3'b010,  5,     -32768, 1'b0, -32768, 1'b1);
        issue("absb_min_011", 3'b011,  5,     -32768, 1'b0, -32768, 1'b1);
        issue("absa_min_110", 3'b110, -32768,  5,     1'b0, -32768, 1'b1);
        issue("absa_min_111", 3'b111, -32768,  5,     1'b0, -32768, 1'b1);
        issue("badd_ovf",     3'b100,  1,      32767, 1'b0, -32768, 1'b1);
        issue("bsub_ovf",     3'b101,  1,     -32768, 1'b0,  32767, 1'b1);
        issue("no_ovf_a",     3'b001,  100,    1,     1'b0,  99,    1'b0);
        issue("no_ovf_b",     3'b101,  -1,     1,     1'b0,  2,     1'b0);
        issue("clr_sticky",   3'b000,  2,      2,     1'b1,  4,     1'b0);
        issue("after_clr",    3'b000,  3,      3,     1'b0,  6,     1'b0);
        issue("clr_vs_ovf",   3'b000, -32768, -1,     1'b1,  32767, 1'b1);
        idle_hold(3);

        // Asynchronous reset mid-stream with in_valid asserted.
        @(negedge clk);
        in_valid = 1'b1;
        OP       = 3'b000;
        A        = 16'd7;
        B        = 16'd8;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_R", {16'h0, R}, 32'h0);
        check("async_reset_ovf", {31'h0, ovf}, 32'h0);
        check("async_reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("async_reset_sticky", {31'h0, ovf_sticky}, 32'h0);
        @(negedge clk);
        check("reset_held_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_held_R", {16'h0, R}, 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        m_sticky = 1'b0;
        issue("post_reset",   3'b001,  50,  8,  1'b0,  42, 1'b0);
        idle_hold(3);

        check("scoreboard_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
